// File: rtl/fp_div_pkg.sv
// Shared types and constants for the sequential single-precision divider.
package fp_div_pkg;

  localparam int          BIAS = 127;
  localparam int          ITER = 25;
  localparam logic [31:0] QNAN = 32'h7FC00000;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    DIVIDE,
    NORM,
    DONE
  } state_t;

endpackage

// File: rtl/fp_div_step.sv
// One restoring shift-subtract iteration: compare, optionally subtract, shift left.
module fp_div_step (
  input  logic [24:0] rem_i,
  input  logic [23:0] div_i,
  output logic [24:0] rem_o,
  output logic        q_o
);

  logic [23:0] diff;

  // The remainder always stays below twice the divisor, so after a subtraction
  // the difference fits in 24 bits and the shifted result fits in 25.
  always_comb begin
    diff  = rem_i[23:0] - div_i;
    q_o   = (rem_i >= {1'b0, div_i});
    rem_o = q_o ? {diff, 1'b0} : {rem_i[23:0], 1'b0};
  end

endmodule

// File: rtl/fp_div_sequencer.sv
// Multi-cycle IEEE-754 single divider: special-case screen, 25 restoring
// iterations, then normalise with truncation and flush/saturate on range errors.
module fp_div_sequencer
  import fp_div_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic        done,
  output logic [31:0] out,
  output logic        underflow,
  output logic        overflow,
  output logic        div_by_zero
);

  localparam logic [4:0]        LAST_ITER = 5'(ITER - 1);
  localparam logic signed [9:0] BIAS10    = 10'(BIAS);

  state_t             state_q, state_d;
  logic [31:0]        a_q, a_d;
  logic [31:0]        b_q, b_d;
  logic signed [9:0]  exp_q, exp_d;
  logic [24:0]        rem_q, rem_d;
  logic [24:0]        quo_q, quo_d;
  logic [4:0]         cnt_q, cnt_d;
  logic [31:0]        out_q, out_d;
  logic               uf_q, uf_d;
  logic               of_q, of_d;
  logic               dz_q, dz_d;

  logic [7:0]         exp_a, exp_b;
  logic               sign;
  logic [23:0]        divisor;
  logic [24:0]        step_rem;
  logic               step_q;
  logic signed [9:0]  norm_exp;
  logic [22:0]        norm_mant;

  assign exp_a   = a_q[30:23];
  assign exp_b   = b_q[30:23];
  assign sign    = a_q[31] ^ b_q[31];
  assign divisor = {1'b1, b_q[22:0]};

  fp_div_step u_step (
    .rem_i (rem_q),
    .div_i (divisor),
    .rem_o (step_rem),
    .q_o   (step_q)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      exp_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
      uf_q    <= 1'b0;
      of_q    <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      exp_q   <= exp_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      uf_q    <= uf_d;
      of_q    <= of_d;
      dz_q    <= dz_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    exp_d     = exp_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    cnt_d     = cnt_q;
    out_d     = out_q;
    uf_d      = uf_q;
    of_d      = of_q;
    dz_d      = dz_q;
    norm_exp  = exp_q;
    norm_mant = quo_q[23:1];

    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = A;
          b_d     = B;
          out_d   = '0;
          uf_d    = 1'b0;
          of_d    = 1'b0;
          dz_d    = 1'b0;
          state_d = CHECK;
        end
      end

      // NaN/infinity operands outrank a zero dividend, which outranks a zero divisor.
      CHECK: begin
        exp_d = {2'b00, exp_a} - {2'b00, exp_b} + BIAS10;
        cnt_d = '0;
        rem_d = {2'b01, a_q[22:0]};
        quo_d = '0;
        if (exp_a == 8'hFF || exp_b == 8'hFF) begin
          out_d   = QNAN;
          state_d = DONE;
        end else if (exp_a == 8'h00) begin
          out_d   = {sign, 31'b0};
          uf_d    = 1'b1;
          state_d = DONE;
        end else if (exp_b == 8'h00) begin
          out_d   = {sign, 8'hFF, 23'b0};
          dz_d    = 1'b1;
          state_d = DONE;
        end else begin
          state_d = DIVIDE;
        end
      end

      DIVIDE: begin
        rem_d = step_rem;
        quo_d = {quo_q[23:0], step_q};
        if (cnt_q == LAST_ITER) begin
          state_d = NORM;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end

      // Quotient lies in (0.5, 2); a missing integer bit costs one exponent step.
      NORM: begin
        if (quo_q[24]) begin
          norm_mant = quo_q[23:1];
          norm_exp  = exp_q;
        end else begin
          norm_mant = quo_q[22:0];
          norm_exp  = exp_q - 10'sd1;
        end
        if (norm_exp >= 10'sd255) begin
          out_d = {sign, 8'hFF, 23'b0};
          of_d  = 1'b1;
        end else if (norm_exp <= 10'sd0) begin
          out_d = {sign, 31'b0};
          uf_d  = 1'b1;
        end else begin
          out_d = {sign, norm_exp[7:0], norm_mant};
        end
        state_d = DONE;
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy        = (state_q == CHECK) || (state_q == DIVIDE) || (state_q == NORM);
  assign done        = (state_q == DONE);
  assign out         = out_q;
  assign underflow   = uf_q;
  assign overflow    = of_q;
  assign div_by_zero = dz_q;

endmodule

// File: tb/tb_fp_div_sequencer.sv
// Scoreboard bench for fp_div_sequencer: directed divides queue expected results,
// an independent monitor checks each done pulse against the queue head.
module tb_fp_div_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] a_in = '0;
  logic [31:0] b_in = '0;
  logic        busy, done, underflow, overflow, div_by_zero;
  logic [31:0] out;

  localparam int LAT_NORMAL  = 28;
  localparam int LAT_SPECIAL = 2;

  typedef struct {
    string       name;
    logic [31:0] out;
    logic        uf;
    logic        of;
    logic        dz;
    int          lat;
    int          start_edge;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   edge_count = 0;
  exp_t mon_e;
  int   mon_lat;

  fp_div_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .A           (a_in),
    .B           (b_in),
    .busy        (busy),
    .done        (done),
    .out         (out),
    .underflow   (underflow),
    .overflow    (overflow),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_count <= edge_count + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp_v);
    end
  endtask

  // Latency counts rising edges from the start-sampling edge to the edge that sees done high.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb.size() == 0) begin
        checkOutput("spurious done", 32'(done), 32'd0);
      end else begin
        mon_e   = sb.pop_front();
        mon_lat = edge_count - mon_e.start_edge + 1;
        checkOutput({mon_e.name, " out"}, out, mon_e.out);
        checkOutput({mon_e.name, " underflow"}, 32'(underflow), 32'(mon_e.uf));
        checkOutput({mon_e.name, " overflow"}, 32'(overflow), 32'(mon_e.of));
        checkOutput({mon_e.name, " div_by_zero"}, 32'(div_by_zero), 32'(mon_e.dz));
        checkOutput({mon_e.name, " latency"}, 32'(mon_lat), 32'(mon_e.lat));
      end
    end
  end

  // noise_at > 0 raises start with unrelated operands for the edge that many cycles after acceptance.
  task automatic applyStimulus(input string name, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] exp_out, input logic uf, input logic of,
                               input logic dz, input int lat, input int noise_at);
    exp_t e;
    @(negedge clk);
    a_in  = a;
    b_in  = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    e.name = name; e.out = exp_out; e.uf = uf; e.of = of; e.dz = dz;
    e.lat = lat; e.start_edge = edge_count;
    sb.push_back(e);
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (k == 1) checkOutput({name, " busy"}, 32'(busy), 32'd1);
      if (k == noise_at) begin
        start = 1'b1;
        a_in  = 32'h40490FDB;
        b_in  = 32'h3F000000;
      end else begin
        start = 1'b0;
      end
      if (sb.size() == 0 && k > noise_at) break;
    end
    start = 1'b0;
    checkOutput({name, " pending"}, 32'(sb.size()), 32'd0);
    sb.delete();
    repeat (2) @(negedge clk);
    checkOutput({name, " idle busy"}, 32'(busy), 32'd0);
  endtask

  task automatic checkAllZero(input string name);
    checkOutput({name, " busy"}, 32'(busy), 32'd0);
    checkOutput({name, " done"}, 32'(done), 32'd0);
    checkOutput({name, " out"}, out, 32'd0);
    checkOutput({name, " underflow"}, 32'(underflow), 32'd0);
    checkOutput({name, " overflow"}, 32'(overflow), 32'd0);
    checkOutput({name, " div_by_zero"}, 32'(div_by_zero), 32'd0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (3) @(negedge clk);
    checkAllZero("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    applyStimulus("basic", 32'h3F700000, 32'h3E300000, 32'h40AE8BA2, 0, 0, 0, LAT_NORMAL, 0);
    repeat (3) @(negedge clk);
    checkOutput("basic held out", out, 32'h40AE8BA2);

    applyStimulus("overflow", 32'h7F500000, 32'hBF400000, 32'hFF800000, 0, 1, 0, LAT_NORMAL, 0);
    applyStimulus("underflow", 32'h00800000, 32'h7F000000, 32'h00000000, 1, 0, 0, LAT_NORMAL, 0);
    applyStimulus("div0", 32'h3F800000, 32'h80000000, 32'hFF800000, 0, 0, 1, LAT_SPECIAL, 2);
    applyStimulus("nan_a", 32'h7FC00000, 32'h3F800000, 32'h7FC00000, 0, 0, 0, LAT_SPECIAL, 0);
    applyStimulus("inf_b", 32'h3F800000, 32'h7F800000, 32'h7FC00000, 0, 0, 0, LAT_SPECIAL, 0);
    applyStimulus("zero_zero", 32'h80000000, 32'h00000000, 32'h80000000, 1, 0, 0, LAT_SPECIAL, 0);
    applyStimulus("two_thirds", 32'h3F800000, 32'h3FC00000, 32'h3F2AAAAA, 0, 0, 0, LAT_NORMAL, 0);
    applyStimulus("exp_one", 32'h00C00000, 32'h3F800000, 32'h00C00000, 0, 0, 0, LAT_NORMAL, 0);
    applyStimulus("norm_uf", 32'h00800000, 32'h3FC00000, 32'h00000000, 1, 0, 0, LAT_NORMAL, 0);
    applyStimulus("exp_254", 32'h7F000000, 32'h3F400000, 32'h7F2AAAAA, 0, 0, 0, LAT_NORMAL, 0);

    applyStimulus("one_by_one", 32'h3F800000, 32'h3F800000, 32'h3F800000, 0, 0, 0, LAT_NORMAL, 10);
    repeat (8) @(negedge clk);
    checkOutput("one_by_one held out", out, 32'h3F800000);
    rst = 1'b1;
    #1;
    checkAllZero("reset pulse");
    @(negedge clk);
    rst = 1'b0;
    applyStimulus("post_reset", 32'h40400000, 32'h3F800000, 32'h40400000, 0, 0, 0, LAT_NORMAL, 0);

    @(negedge clk);
    a_in  = 32'h3F700000;
    b_in  = 32'h3E300000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    checkOutput("abort busy before reset", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    checkAllZero("abort");
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    checkOutput("abort no done", 32'(done), 32'd0);
    applyStimulus("after_abort", 32'h3F700000, 32'h3E300000, 32'h40AE8BA2, 0, 0, 0, LAT_NORMAL, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/fp_div_sequencer.md
FP_DIV_SEQUENCER -- requirements
Module: fp_div_sequencer

Interface
REQ-001 The module SHALL have exactly one clock and one reset; reset is asynchronous and active-high.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 start  input  1  request a divide; sampled only in IDLE.
REQ-005 A  input  32  IEEE-754 single dividend; sampled with start.
REQ-006 B  input  32  IEEE-754 single divisor; sampled with start.
REQ-007 busy  output  1  high from the cycle after start is accepted until done.
REQ-008 done  output  1  one-cycle pulse; out and flags are valid.
REQ-009 out  output  32  quotient A/B, held until the next accepted start.
REQ-010 underflow  output  1  result flushed to signed zero.
REQ-011 overflow  output  1  result saturated to signed infinity.
REQ-012 div_by_zero  output  1  B is zero and A is a normal number.

Function
REQ-013 FSM states SHALL be IDLE, CHECK, DIVIDE, NORM, DONE.
REQ-014 IDLE->CHECK on start=1; A and B registered; out and flags cleared.
REQ-015 start while not IDLE SHALL be ignored, with no effect on the operation in flight.
REQ-016 CHECK SHALL compute the sign as A[31]^B[31] and the exponent as eA-eB+127 in 10-bit signed arithmetic.
REQ-017 CHECK SHALL go directly to DONE for special cases, in priority order:
- any exponent 255: out=0x7FC00000, all flags 0;
- eA=0: out={sign,31'b0}, underflow=1 (denormal or zero A is flushed);
- eB=0: out={sign,8'hFF,23'b0}, div_by_zero=1.
REQ-018 Otherwise CHECK->DIVIDE. DIVIDE SHALL run exactly 25 restoring shift-subtract iterations on 1.mA / 1.mB, one per cycle, producing q[24:0] with q[24] weighted 2^0.
REQ-019 NORM case q[24]=1: mantissa = q[23:1], exponent unchanged.
REQ-020 NORM case q[24]=0: mantissa = q[22:0], exponent minus 1.
REQ-021 Rounding SHALL be truncation.
REQ-022 NORM: exponent >= 255 -> out={sign,8'hFF,23'b0}, overflow=1.
REQ-023 NORM: exponent <= 0 -> out={sign,31'b0}, underflow=1.
REQ-024 NORM otherwise: out={sign,exp[7:0],mantissa}.
REQ-025 Latency from the start-sampling edge (cycle 0):
- normal path: done high in cycle 28 (CHECK 1, DIVIDE 2-26, NORM 27);
- special path: done high in cycle 2.
REQ-026 DONE SHALL assert done and deassert busy; DONE->IDLE next cycle; a start in DONE SHALL be ignored.
REQ-027 The iteration counter SHALL be 5 bits, load 0 in CHECK, and leave DIVIDE when it reaches 24; no wrap-around.

Reset
REQ-028 While rst=1, the FSM SHALL be IDLE and busy, done, out, underflow, overflow, div_by_zero and all internal registers SHALL be 0.
REQ-029 Reset mid-operation SHALL abort without a done pulse; the first start after rst falls SHALL be accepted normally.

Structure
REQ-030 Package fp_div_pkg SHALL hold the state enum, BIAS=127, ITER=25 and QNAN=32'h7FC00000.
REQ-031 Sub-module fp_div_step SHALL be combinational: partial remainder and divisor in; next remainder and quotient bit out. It is instantiated once.

Verification
REQ-032 A=0x3F700000, B=0x3E300000 -> cycle 28: done, out=0x40AE8BA2, flags 0.
REQ-033 A=0x7F500000, B=0xBF400000 -> cycle 28: out=0xFF800000, overflow=1.
REQ-034 A=0x00800000, B=0x7F000000 -> cycle 28: out=0x00000000, underflow=1.
REQ-035 A=0x3F800000, B=0x80000000 -> cycle 2: out=0xFF800000, div_by_zero=1.
REQ-036 A=B=0x3F800000, second start at cycle 10, rst pulse at cycle 40, then a new start -> the second start is ignored; the first done is at cycle 28 with out=0x3F800000; the post-reset op completes normally.
REQ-037 rst asserted at cycle 15 of an operation -> no done pulse, all outputs 0 immediately.
